// File: rtl/bpu_btb_pkg.sv
// Shared widths and counter encodings for the branch target buffer.
package bpu_btb_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned BtbEntries  = 16;
  localparam int unsigned BtbIdxW     = $clog2(BtbEntries);
  localparam int unsigned BtbTagW     = InstAddrBus - 2 - BtbIdxW;

  // 2-bit saturating direction counter; MSB set means predict taken.
  typedef logic [1:0] ctr_t;

  localparam ctr_t CtrStrongNt = 2'b00;
  localparam ctr_t CtrWeakNt   = 2'b01;
  localparam ctr_t CtrWeakT    = 2'b10;
  localparam ctr_t CtrStrongT  = 2'b11;

endpackage

// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational on pc_i; one resolved-branch update per cycle is
// written at the next rising edge, so same-cycle lookups see old contents.
module bpu_btb
  import bpu_btb_pkg::*;
#(
  parameter int unsigned ENTRIES = BtbEntries
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [InstAddrBus-1:0] pc_i,
  output logic                   isbranch_o,
  output logic [InstAddrBus-1:0] branch_addr_o,
  input  logic                   upd_valid_i,
  input  logic [InstAddrBus-1:0] upd_pc_i,
  input  logic                   upd_taken_i,
  input  logic [InstAddrBus-1:0] upd_target_i,
  input  logic                   flush_i
);

  localparam int unsigned IdxW = $clog2(ENTRIES);
  localparam int unsigned TagW = InstAddrBus - 2 - IdxW;

  function automatic ctr_t sat_ctr(ctr_t cur, logic taken);
    ctr_t nxt;
    if (taken) begin
      nxt = (cur == CtrStrongT) ? cur : ctr_t'(cur + 2'b01);
    end else begin
      nxt = (cur == CtrStrongNt) ? cur : ctr_t'(cur - 2'b01);
    end
    return nxt;
  endfunction

  logic                   valid_q  [ENTRIES];
  logic [TagW-1:0]        tag_q    [ENTRIES];
  logic [InstAddrBus-1:0] target_q [ENTRIES];
  ctr_t                   ctr_q    [ENTRIES];

  logic [IdxW-1:0] rd_idx;
  logic [TagW-1:0] rd_tag;
  logic            rd_hit;

  logic [IdxW-1:0]        upd_idx;
  logic [TagW-1:0]        upd_tag;
  logic                   upd_hit;
  logic                   upd_we;
  ctr_t                   upd_ctr_d;
  logic [InstAddrBus-1:0] upd_target_d;

  // Byte-offset bits never take part in indexing or tagging.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{pc_i[1:0], upd_pc_i[1:0]};

  // Combinational lookup; prediction suppressed while reset or flush is active.
  always_comb begin
    rd_idx        = pc_i[IdxW+1:2];
    rd_tag        = pc_i[InstAddrBus-1:IdxW+2];
    rd_hit        = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    isbranch_o    = rd_hit && ctr_q[rd_idx][1] && !rst && !flush_i;
    branch_addr_o = isbranch_o ? target_q[rd_idx] : '0;
  end

  // Update decode: train on a hit, allocate on a taken miss, drop a not-taken miss.
  always_comb begin
    upd_idx      = upd_pc_i[IdxW+1:2];
    upd_tag      = upd_pc_i[InstAddrBus-1:IdxW+2];
    upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_we       = upd_valid_i && (upd_hit || upd_taken_i);
    upd_ctr_d    = upd_hit ? sat_ctr(ctr_q[upd_idx], upd_taken_i) : CtrWeakT;
    upd_target_d = upd_taken_i ? upd_target_i : target_q[upd_idx];
  end

  // Table storage: reset beats flush, flush beats any update in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CtrWeakNt;
      end
    end else if (flush_i) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_we) begin
      valid_q[upd_idx]  <= 1'b1;
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= upd_target_d;
      ctr_q[upd_idx]    <= upd_ctr_d;
    end
  end

endmodule

// File: tb/tb_bpu_btb.sv
// Self-checking bench for bpu_btb: directed vector table, then random traffic
// against a word-address-keyed reference model.
module tb_bpu_btb;

  localparam int unsigned N = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0;
  logic        isbranch;
  logic [31:0] branch_addr;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        flush = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bpu_btb #(.ENTRIES(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc),
    .isbranch_o   (isbranch),
    .branch_addr_o(branch_addr),
    .upd_valid_i  (upd_valid),
    .upd_pc_i     (upd_pc),
    .upd_taken_i  (upd_taken),
    .upd_target_i (upd_target),
    .flush_i      (flush)
  );

  typedef struct packed {
    logic        rst;
    logic        flush;
    logic        uv;
    logic        taken;
    logic [31:0] pc;
    logic [31:0] upd_pc;
    logic [31:0] tgt;
    logic        isb;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic f, logic uv, logic t, logic [31:0] p,
                              logic [31:0] up, logic [31:0] tg, logic isb,
                              logic [31:0] addr);
    vec_t v;
    v.rst = r; v.flush = f; v.uv = uv; v.taken = t; v.pc = p;
    v.upd_pc = up; v.tgt = tg; v.isb = isb; v.addr = addr;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge.
  task automatic drive(logic r, logic f, logic uv, logic t, logic [31:0] p,
                       logic [31:0] up, logic [31:0] tg);
    @(posedge clk);
    #1;
    rst = r; flush = f; upd_valid = uv; upd_taken = t;
    pc = p; upd_pc = up; upd_target = tg;
  endtask

  // Reference model: each slot remembers the full word address that owns it.
  bit          m_valid [N];
  logic [29:0] m_word  [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];

  function automatic int slot_of(logic [31:0] a);
    return int'((a >> 2) % N);
  endfunction

  function automatic bit m_hit(logic [31:0] a);
    int s;
    s = slot_of(a);
    return m_valid[s] && (m_word[s] == a[31:2]);
  endfunction

  task automatic m_step(logic r, logic f, logic uv, logic t, logic [31:0] up,
                        logic [31:0] tg);
    int s;
    s = slot_of(up);
    if (r) begin
      for (int i = 0; i < int'(N); i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 1;
      end
    end else if (f) begin
      for (int i = 0; i < int'(N); i++) m_valid[i] = 1'b0;
    end else if (uv) begin
      if (m_hit(up)) begin
        m_ctr[s] = t ? ((m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1)
                     : ((m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1);
        if (t) m_tgt[s] = tg;
      end else if (t) begin
        m_valid[s] = 1'b1;
        m_word[s]  = up[31:2];
        m_tgt[s]   = tg;
        m_ctr[s]   = 2;
      end
    end
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] a;
    a = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
    return a;
  endfunction

  initial begin
    // Directed sequence; expectations are the outputs seen during each cycle.
    vecs.push_back(mk(1, 0, 0, 0, 32'h100, 32'h0,   32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h100, 32'h0,   32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h100, 32'h100, 32'h80,  0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h100, 32'h0,   32'h0,   1, 32'h80));
    vecs.push_back(mk(0, 0, 1, 0, 32'h100, 32'h100, 32'h0,   1, 32'h80));
    vecs.push_back(mk(0, 0, 1, 0, 32'h100, 32'h100, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h100, 32'h100, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h100, 32'h100, 32'h84,  0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h100, 32'h100, 32'h88,  0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h100, 32'h0,   32'h0,   1, 32'h88));
    vecs.push_back(mk(0, 0, 1, 1, 32'h100, 32'h140, 32'h300, 1, 32'h88));
    vecs.push_back(mk(0, 0, 0, 0, 32'h100, 32'h0,   32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h140, 32'h0,   32'h0,   1, 32'h300));
    vecs.push_back(mk(0, 0, 1, 1, 32'h200, 32'h200, 32'h400, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h200, 32'h0,   32'h0,   1, 32'h400));
    vecs.push_back(mk(0, 0, 0, 0, 32'h202, 32'h0,   32'h0,   1, 32'h400));
    vecs.push_back(mk(0, 0, 1, 1, 32'h200, 32'h200, 32'h404, 1, 32'h400));
    vecs.push_back(mk(0, 0, 1, 1, 32'h200, 32'h200, 32'h408, 1, 32'h404));
    vecs.push_back(mk(0, 0, 1, 0, 32'h200, 32'h200, 32'h999, 1, 32'h408));
    vecs.push_back(mk(0, 0, 0, 0, 32'h200, 32'h0,   32'h0,   1, 32'h408));
    vecs.push_back(mk(0, 0, 1, 0, 32'h304, 32'h304, 32'h999, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h304, 32'h304, 32'h111, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h304, 32'h0,   32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 1, 32'h200, 32'h240, 32'h500, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h200, 32'h0,   32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h140, 32'h0,   32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h240, 32'h0,   32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h200, 32'h200, 32'h600, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h200, 32'h0,   32'h0,   1, 32'h600));
    vecs.push_back(mk(1, 0, 1, 1, 32'h200, 32'h180, 32'h700, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h200, 32'h0,   32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h180, 32'h0,   32'h0,   0, 32'h0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].uv, vecs[i].taken, vecs[i].pc,
            vecs[i].upd_pc, vecs[i].tgt);
      @(negedge clk);
      check($sformatf("vec%0d isbranch", i), {31'b0, isbranch}, {31'b0, vecs[i].isb});
      check($sformatf("vec%0d branch_addr", i), branch_addr, vecs[i].addr);
    end

    // Random phase: start from reset so the model and DUT agree.
    for (int n = 0; n < 2000; n++) begin
      logic        r, f, uv, t, eisb;
      logic [31:0] p, up, tg, eaddr;
      int          s;
      r  = (n == 0) || ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 99) == 0);
      uv = ($urandom_range(0, 9) < 6);
      t  = ($urandom_range(0, 2) != 0);
      p  = rand_pc();
      up = ($urandom_range(0, 3) == 0) ? p : rand_pc();
      tg = $urandom;
      s  = slot_of(p);
      eisb  = !r && !f && m_hit(p) && (m_ctr[s] >= 2);
      eaddr = eisb ? m_tgt[s] : 32'h0;
      drive(r, f, uv, t, p, up, tg);
      @(negedge clk);
      check($sformatf("rnd%0d isbranch", n), {31'b0, isbranch}, {31'b0, eisb});
      check($sformatf("rnd%0d branch_addr", n), branch_addr, eaddr);
      m_step(r, f, uv, t, up, tg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
